// File: rtl/order_failure_handler_pkg.sv
// ----------------------------------------------------------------------------
// order_failure_handler_pkg
// Types and helpers shared by the load/store-unit control blocks.
//   LDQ_INDEX_WIDTH : index width of the default 8-entry load queue
//   ofh_state_e     : request state of the order-failure handler
//   ldq_age()       : distance of a queue entry from the queue head
//                     (power-of-two queue sizes only)
// ----------------------------------------------------------------------------
package order_failure_handler_pkg;

    localparam int LDQ_INDEX_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } ofh_state_e;

    // (idx - head) mod size; the unsigned subtraction wraps, the mask folds it
    // back into the queue, so a head near the top still sees index 0 as young.
    function automatic int unsigned ldq_age(input int unsigned idx,
                                            input int unsigned head,
                                            input int unsigned size);
        return (idx - head) & (size - 32'd1);
    endfunction

endpackage

// File: rtl/order_failure_handler_oldest_select.sv
// ----------------------------------------------------------------------------
// order_failure_handler_oldest_select
// Combinational picker: finds the set mask bit closest to the queue head.
//   i_mask  : candidate entries
//   i_head  : index of the oldest queue entry
//   o_found : at least one candidate is set
//   o_index : index of the oldest candidate (0 when none)
//   o_age   : its distance from the head (0 when none)
// ----------------------------------------------------------------------------
module order_failure_handler_oldest_select
    import order_failure_handler_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int IW   = $clog2(SIZE)
) (
    input  logic [SIZE-1:0] i_mask,
    input  logic [IW-1:0]   i_head,
    output logic            o_found,
    output logic [IW-1:0]   o_index,
    output logic [IW-1:0]   o_age
);

    // Walk from youngest to oldest so the last hit, the oldest, wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        o_age   = '0;
        for (int a = SIZE - 1; a >= 0; a--) begin
            if (i_mask[i_head + IW'(a)]) begin
                o_found = 1'b1;
                o_index = i_head + IW'(a);
                o_age   = IW'(a);
            end
        end
    end

endmodule

// File: rtl/order_failure_handler.sv
// ----------------------------------------------------------------------------
// order_failure_handler
// Collects load ordering failures reported by the LSU searcher and issues
// one flush request at a time to the ROB for the oldest failing load.
//   clk, reset       : clock, asynchronous active-high reset
//   order_failures   : per-LDQ-entry failure pulses
//   ldq_valid        : LDQ entry allocated
//   ldq_rob_tag      : ROB tag of every LDQ entry
//   ldq_head         : oldest LDQ entry (index + wrap bit)
//   flush_valid/ready: request handshake towards the ROB
//   flush_rob_tag    : ROB tag of the failing load
//   flush_ldq_index  : LDQ index of the failing load
//   flush_done       : ROB reports the requested flush has finished
//   global_flush     : unrelated whole-LSU flush, dominates everything
//   busy             : request in progress or failures still pending
// ----------------------------------------------------------------------------
module order_failure_handler
    import order_failure_handler_pkg::*;
#(
    parameter int LDQ_SIZE      = 8,
    parameter int LDQ_TAG_WIDTH = 4,
    parameter int ROB_TAG_WIDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [LDQ_SIZE-1:0]                     order_failures,
    input  logic [LDQ_SIZE-1:0]                     ldq_valid,
    input  logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]  ldq_rob_tag,
    input  logic [LDQ_TAG_WIDTH-1:0]                ldq_head,
    output logic                                    flush_valid,
    input  logic                                    flush_ready,
    output logic [ROB_TAG_WIDTH-1:0]                flush_rob_tag,
    output logic [$clog2(LDQ_SIZE)-1:0]             flush_ldq_index,
    input  logic                                    flush_done,
    input  logic                                    global_flush,
    output logic                                    busy
);

    localparam int IW = $clog2(LDQ_SIZE);

    ofh_state_e                 r_state;
    logic [LDQ_SIZE-1:0]        r_pending;
    logic [IW-1:0]              r_sel_idx;
    logic [ROB_TAG_WIDTH-1:0]   r_sel_tag;

    ofh_state_e                 w_state_next;
    logic [LDQ_SIZE-1:0]        w_accum;
    logic [LDQ_SIZE-1:0]        w_older_mask;
    logic [LDQ_SIZE-1:0]        w_pending_next;
    logic                       w_trim;
    logic                       w_sel_load;
    logic [IW-1:0]              w_head;
    logic [IW-1:0]              w_reg_age;
    logic                       w_pick_found;
    logic [IW-1:0]              w_pick_idx;
    logic [IW-1:0]              w_pick_age;
    logic                       w_unused_head_wrap;

    // The wrap bit only matters for full/empty detection elsewhere.
    assign w_head             = ldq_head[IW-1:0];
    assign w_unused_head_wrap = ldq_head[LDQ_TAG_WIDTH-1];

    assign w_reg_age = IW'(ldq_age(32'(r_sel_idx), 32'(w_head), LDQ_SIZE));
    assign w_accum   = (r_pending | order_failures) & ldq_valid;

    // Entries strictly older than the registered (flushed) load survive its
    // flush; everything at or after it is squashed by the ROB anyway.
    always_comb begin
        w_older_mask = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            w_older_mask[i] = IW'(ldq_age(32'(i), 32'(w_head), LDQ_SIZE)) < w_reg_age;
        end
    end

    // Trim on the handshake cycle and for the whole wait for flush_done.
    assign w_trim = ((r_state == REQ) && flush_ready) || (r_state == WAIT_DONE);

    assign w_pending_next = global_flush ? '0
                          : (w_trim ? (w_accum & w_older_mask) : w_accum);

    order_failure_handler_oldest_select #(
        .SIZE (LDQ_SIZE),
        .IW   (IW)
    ) u_oldest_select (
        .i_mask  (w_pending_next),
        .i_head  (w_head),
        .o_found (w_pick_found),
        .o_index (w_pick_idx),
        .o_age   (w_pick_age)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and selection-load decision
    always_comb begin
        w_state_next = r_state;
        w_sel_load   = 1'b0;
        if (global_flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_found) begin
                        w_state_next = REQ;
                        w_sel_load   = 1'b1;
                    end
                end
                REQ: begin
                    if (flush_ready) begin
                        // ROB took the registered tag; keep it for trimming.
                        w_state_next = WAIT_DONE;
                    end else if (!w_pick_found) begin
                        w_state_next = IDLE;
                    end else if ((w_pick_age < w_reg_age) || !w_pending_next[r_sel_idx]) begin
                        // Older failure preempts, or the registered load left the LDQ.
                        w_sel_load = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (flush_done) begin
                        if (w_pick_found) begin
                            w_state_next = REQ;
                            w_sel_load   = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Pending mask and registered selection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_sel_idx <= '0;
            r_sel_tag <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_sel_load) begin
                r_sel_idx <= w_pick_idx;
                r_sel_tag <= ldq_rob_tag[w_pick_idx];
            end
        end
    end

    // Outputs
    always_comb begin
        flush_valid     = (r_state == REQ);
        flush_rob_tag   = r_sel_tag;
        flush_ldq_index = r_sel_idx;
        busy            = (r_state != IDLE) || (r_pending != '0);
    end

endmodule

// File: doc/order_failure_handler.md
Name: order_failure_handler

Overview:
- Consumes the per-load order-failure vector from the LSU searcher, which flags loads that received stale data when a store fires.
- Accumulates flagged loads and selects the oldest one relative to the LDQ head.
- Issues a single registered flush request, carrying that load's ROB tag, to the ROB over a valid/ready handshake.
- Sits between the LSU searcher and the ROB/flush controller.

Parameters:
- LDQ_SIZE, 8, number of load queue entries (power of two).
- LDQ_TAG_WIDTH, 4, LDQ index plus one wrap bit; equals $clog2(LDQ_SIZE)+1.
- ROB_TAG_WIDTH, 5, width of a ROB tag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- order_failures  in  LDQ_SIZE  per-entry failure flags from the searcher; a bit is valid only in its cycle.
- ldq_valid  in  LDQ_SIZE  LDQ entry allocated.
- ldq_rob_tag  in  LDQ_SIZE x ROB_TAG_WIDTH  ROB tag of each LDQ entry.
- ldq_head  in  LDQ_TAG_WIDTH  oldest LDQ entry.
- flush_valid  out  1  flush request pending.
- flush_ready  in  1  ROB accepts the request.
- flush_rob_tag  out  ROB_TAG_WIDTH  ROB tag of the failing load; the load and everything younger are flushed.
- flush_ldq_index  out  $clog2(LDQ_SIZE)  LDQ index of the failing load.
- flush_done  in  1  ROB pulse: the requested flush has completed.
- global_flush  in  1  unrelated pipeline flush, for example a branch mispredict; the whole LSU is cleared.
- busy  out  1  state != IDLE or the pending mask is nonzero.

Behaviour:
- Reset values:
  - All outputs are 0.
  - pending mask is 0.
  - state is IDLE.
  - Registered selection is 0.
- Pending mask:
  - Each cycle: pending_next = (pending | order_failures) & ldq_valid.
  - Entries that are deallocated are dropped.
- Age:
  - age(i) = (i - ldq_head[index bits]) mod LDQ_SIZE, computed unsigned in index width.
  - The smallest age is the oldest. Ties are impossible.
  - Selection = oldest set bit of pending_next.
- States:
  - IDLE: flush_valid=0. If pending_next != 0, register the selection (index and ldq_rob_tag[sel]) and go to REQ. Latency: a failure in cycle N produces flush_valid=1 in N+1.
  - REQ: flush_valid=1.
    - Each cycle, re-evaluate the selection.
    - If the oldest pending entry is older than the registered one, replace flush_rob_tag/flush_ldq_index next cycle (preemption). The ROB samples only on the handshake cycle.
    - If the registered entry is dropped (its ldq_valid goes low) and the mask is nonzero, re-select the oldest.
    - If the mask becomes empty, go to IDLE and deassert.
    - On flush_valid & flush_ready, go to WAIT_DONE.
  - Handshake cycle:
    - Clear from pending_next every entry whose age is >= age(registered); these are flushed anyway.
    - Older entries, including ones arriving that cycle, stay pending.
  - WAIT_DONE: flush_valid=0.
    - Keep accumulating order_failures only for entries older than the flushed load; mask younger-or-equal ones.
    - On flush_done, go to IDLE, or go directly to REQ with a new selection if the mask is nonzero.
- global_flush has priority over everything in the same cycle:
  - pending is set to 0 and state to IDLE; flush_valid goes 0 next cycle.
  - A simultaneous handshake is ignored by this block; the ROB treats global_flush as dominant.
- A flush_done seen outside WAIT_DONE is ignored.
- An asynchronous reset mid-request drops flush_valid immediately, with no handshake completion.
- LDQ full wrap-around:
  - Age uses modulo arithmetic, so a head at index LDQ_SIZE-1 makes index 0 the second-oldest.
- Multiple simultaneous failures are all captured; exactly one request is outstanding at any time.

Decomposition:
- Shared lsu package holds:
  - LDQ_INDEX_WIDTH.
  - A state enum: IDLE, REQ, WAIT_DONE.
  - An age function (index - head) mod size, reused by the LDQ/STQ logic.
- Natural sub-module: oldest_select, a combinational priority picker over a mask given a head index. It outputs found, index and age, and is reusable for LDQ/STQ issue arbitration.

Test Plan:
- Single failure: head=0, order_failures=8'b0000_0100 for 1 cycle, ldq_rob_tag[2]=5'd9 -> next cycle flush_valid=1, flush_ldq_index=2, flush_rob_tag=9. flush_ready=1 -> WAIT_DONE. flush_done -> IDLE, busy=0.
- Wrap-around oldest: head=6, failures on entries 1 and 7 in the same cycle -> selects 7 (age 1). After handshake, entry 1 (age 3, younger) is discarded.
- Preemption: in REQ with entry 5 registered (head=2), failure on entry 3 arrives with flush_ready=0 -> next cycle flush_ldq_index=3. A handshake then reports the ROB tag of entry 3.
- Older failure during WAIT_DONE: flushed entry 4 (head=0), failure on entry 1 during WAIT_DONE, failure on entry 6 ignored -> on flush_done, next cycle flush_valid=1 with index 1.
- Deallocation drop: pending only entry 2, ldq_valid[2] falls while in REQ with flush_ready=0 -> flush_valid goes 0 next cycle, state IDLE.
- global_flush in the same cycle as a new failure and a handshake -> pending=0, IDLE, no request next cycle. Assert reset mid-REQ -> flush_valid=0 asynchronously.
